fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 24 ++
 rtl/fifo_stream_reader.sv | 93 +++++++++
 2 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for fifo_stream_reader and the fifo it drains:
// FSM encoding and default block geometry.
package fifo_stream_reader_pkg;

  localparam int DEF_FIFO_SIZE  = 8;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POP   = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    POP   = ST_POP,
    LATCH = ST_LATCH,
    SEND  = ST_SEND
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains one FIFO_SIZE-word block from a fifo and presents it as a
// valid/ready stream, one word per POP/LATCH/SEND round trip.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int FIFO_SIZE  = DEF_FIFO_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_ready,
  input  logic                  fifo_pushed_last,
  input  logic                  fifo_popped_last,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  block_error,
  output logic [15:0]           block_count
);

  localparam int            IW       = idx_width(FIFO_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(FIFO_SIZE - 1);

  state_t        state;
  logic [IW-1:0] word_index;
  logic          at_last_idx;

  assign at_last_idx = (word_index == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      word_index  <= '0;
      fifo_pop    <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      block_error <= 1'b0;
      block_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && fifo_pushed_last) begin
            state      <= POP;
            busy       <= 1'b1;
            word_index <= '0;
          end
        end
        POP: begin
          if (fifo_ready) begin
            fifo_pop <= 1'b1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          // The fifo updates its output on the pop rising edge, so the
          // word is stable by the end of this cycle.
          fifo_pop <= 1'b0;
          m_data   <= fifo_data;
          m_valid  <= 1'b1;
          m_last   <= at_last_idx || fifo_popped_last;
          if (fifo_popped_last != at_last_idx) block_error <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              block_count <= block_count + 16'd1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              word_index <= word_index + IW'(1);
              state      <= POP;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
